lcd_bus_arbiter: RTL
====================

# lcd_bus_arbiter

Shares the 8-bit 8080-style LCD write bus (`wr`, `dcx`, `D`) between two byte requesters and generates the `wr` strobe timing. Requester 0 is the command/init sequencer; requester 1 is the pixel updater.

- Ownership is held for a whole burst, so command/parameter sequences such as CASET/PASET/RAMWR are never interleaved.
- Arbitration between bursts is round-robin.
- The block sits between the requesters and the top-level LCD pins.

## Interface
Parameters:
- `WR_LOW`, default 1: cycles `wr` is held low per byte; legal range ≥1.
- `WR_HIGH`, default 1: cycles `wr` is held high after the rising edge, before the next byte may be accepted; legal range ≥1.

Ports:
- `clk` in 1: the single clock; all logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req0_valid` in 1: requester 0 has a byte; must stay high with stable data until `req0_ready`.
- `req0_dcx` in 1: 0 = command, 1 = data.
- `req0_data` in 8: byte to write.
- `req0_last` in 1: this byte ends requester 0's burst.
- `req0_ready` out 1: byte accepted this cycle (combinational).
- `req1_valid`, `req1_dcx`, `req1_data[7:0]`, `req1_last`, `req1_ready`: same as requester 0, for requester 1.
- `wr` out 1: LCD write strobe; the panel latches on the rising edge.
- `dcx` out 1: registered D/C select.
- `D` out 8: registered data bus.
- `grant` out 2: one-hot current owner; 00 when no owner.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
State machine: IDLE, STROBE_LO, STROBE_HI, WAIT_NEXT.

IDLE (no owner):
- Winner is the valid requester. If both are valid, the winner is the requester not served last; `last_served` resets to 1, so req0 wins the first tie.
- `ready` goes high for the winner in the same cycle.
- On that edge: owner := winner; `D`, `dcx` and the last-flag are latched; `last_served` := winner; state → STROBE_LO.

STROBE_LO:
- `wr` = 0.
- After `WR_LOW` cycles → STROBE_HI.

STROBE_HI:
- `wr` = 1.
- After `WR_HIGH` cycles: if the latched last-flag = 1 → IDLE, owner released, `grant` = 00; otherwise → WAIT_NEXT.

WAIT_NEXT:
- Only the owner can be accepted; the other requester's `ready` stays 0 even if it is valid.
- When the owner is valid: `ready` = 1, latch, → STROBE_LO.

General rules:
- `D`/`dcx` change only on an accept edge and are held until the next accept.
- `ready` is never asserted in STROBE_LO or STROBE_HI.
- At most one `ready` is high in any cycle.
- There is no timeout in WAIT_NEXT: the owner must eventually send a `last` byte.

## Timing
- Reset values: `wr` = 1, `dcx` = 1, `D` = 0x00, `grant` = 00, `busy` = 0, both `ready` = 0, `last_served` = 1, state IDLE.
- Accept in cycle n:
  - `D`/`dcx` are valid from n+1.
  - `wr` = 0 in cycles n+1 … n+WR_LOW.
  - `wr` = 1 from n+WR_LOW+1.
  - Earliest next accept is cycle n+WR_LOW+WR_HIGH+1.
- Throughput: one byte per WR_LOW+WR_HIGH+1 cycles.
- `grant` updates on the accept edge in IDLE and clears on the exit edge of the final STROBE_HI.
- `busy` is high from n+1 until return to IDLE.
- Simultaneous valid in IDLE: round-robin as described; the loser sees `ready` = 0 and must keep `valid` high.
- Valid dropped before `ready`: no effect and no latch.
- `rst` asserted mid-strobe: the next cycle shows the reset values (`wr` returns high); the burst is abandoned and the requester restarts its sequence.
- Strobe counter width: `$clog2(max(WR_LOW, WR_HIGH)+1)`. It reloads on each state entry and counts down to 1; no wrap is possible.

## Structure
- Package `lcd_bus_pkg`:
  - `state_t` enum (IDLE, STROBE_LO, STROBE_HI, WAIT_NEXT);
  - requester index constants `REQ_CMD` = 0, `REQ_PIX` = 1;
  - `DCX_CMD` = 0, `DCX_DATA` = 1.
- Sub-module `lcd_wr_timer`: loadable down-counter with a `done` pulse, used for both strobe phases.
- The arbiter FSM, latches and round-robin pointer live in the top module.

## Test plan
- Reset, then a single req0 byte 0x2A, `dcx` = 0, `last` = 1 (WR_LOW = WR_HIGH = 1):
  - `req0_ready` is high in cycle 0;
  - D = 0x2A and `dcx` = 0 from cycle 1;
  - `wr` = 0 in cycle 1 only;
  - `grant` = 01 in cycles 1–2, 00 from cycle 3.
- req0 burst 0x2A, 0x00, 0x10 (last on 0x10) while req1 is held valid throughout:
  - `req1_ready` stays 0 until after 0x10's STROBE_HI;
  - req1 is accepted in the next IDLE cycle.
- Both valid out of reset with `last` = 1 each, repeated four times: grants alternate 01, 10, 01, 10.
- WR_LOW = 3, WR_HIGH = 2, req1 byte 0xF8 `dcx` = 1:
  - `wr` low for exactly 3 cycles, then high for 2;
  - next accept no earlier than 6 cycles after the first.
- `rst` pulsed during STROBE_LO of a req1 burst:
  - the next cycle shows `wr` = 1, D = 0x00, `dcx` = 1, `grant` = 00, `busy` = 0;
  - a subsequent req1 byte is accepted normally.
- Owner in WAIT_NEXT with `valid` low for 10 cycles: `wr` stays 1, D stays unchanged, and `grant` stays held.

Source files
------------

// File: rtl/lcd_bus_arbiter_pkg.sv
// Shared types and constants for the LCD write-bus arbiter.
//   state_t           : arbiter FSM states
//   REQ_CMD / REQ_PIX : requester indices (command sequencer, pixel updater)
//   DCX_CMD / DCX_DATA: values of the D/C select line
package lcd_bus_pkg;
  typedef enum logic [1:0] {IDLE, STROBE_LO, STROBE_HI, WAIT_NEXT} state_t;

  localparam logic REQ_CMD  = 1'b0;
  localparam logic REQ_PIX  = 1'b1;

  localparam logic DCX_CMD  = 1'b0;
  localparam logic DCX_DATA = 1'b1;
endpackage

// File: rtl/lcd_bus_arbiter_if.sv
// Requester handshakes plus the LCD pin side of the arbiter.
//   master: requester/pin-consumer view (drives valid/dcx/data/last)
//   slave : arbiter view (drives ready, wr, dcx, D, grant, busy)
interface lcd_bus_arbiter_if;
  logic       req0_valid, req0_dcx, req0_last, req0_ready;
  logic [7:0] req0_data;
  logic       req1_valid, req1_dcx, req1_last, req1_ready;
  logic [7:0] req1_data;
  logic       wr, dcx, busy;
  logic [7:0] D;
  logic [1:0] grant;

  modport master (
    output req0_valid, req0_dcx, req0_data, req0_last,
    output req1_valid, req1_dcx, req1_data, req1_last,
    input  req0_ready, req1_ready, wr, dcx, D, grant, busy
  );

  modport slave (
    input  req0_valid, req0_dcx, req0_data, req0_last,
    input  req1_valid, req1_dcx, req1_data, req1_last,
    output req0_ready, req1_ready, wr, dcx, D, grant, busy
  );
endinterface

// File: rtl/lcd_bus_arbiter_wr_timer.sv
// Loadable down-counter timing one strobe phase.
//   clk, rst : clock, synchronous active-high reset
//   load     : reload with load_val (takes priority over counting)
//   load_val : phase length in cycles, >= 1
//   done     : high in the last cycle of the loaded phase (single pulse)
// The count parks at 0 after reaching 1, so done never repeats or wraps.
module lcd_wr_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)                cnt <= '0;
    else if (load)          cnt <= load_val;
    else if (cnt != '0)     cnt <= cnt - W'(1);
  end

  assign done = (cnt == W'(1));
endmodule

// File: rtl/lcd_bus_arbiter.sv
// Two-requester arbiter for the 8080-style LCD write bus.
//   clk, rst : clock, synchronous active-high reset
//   bus      : requester handshakes (req0 = command sequencer, req1 = pixel
//              updater) and LCD pins wr/dcx/D, plus grant and busy status
// Ownership is kept for a whole burst (until a byte with last=1 has been
// strobed); between bursts the owner is chosen round-robin.
module lcd_bus_arbiter
  import lcd_bus_pkg::*;
#(
  parameter int WR_LOW  = 1,
  parameter int WR_HIGH = 1
) (
  input  logic clk,
  input  logic rst,
  lcd_bus_arbiter_if.slave bus
);
  localparam int MAX_PH = (WR_LOW > WR_HIGH) ? WR_LOW : WR_HIGH;
  localparam int CW     = $clog2(MAX_PH + 1);

  state_t     state;
  logic       owner, last_served, last_q;
  logic       wr_q, dcx_q;
  logic [7:0] d_q;
  logic [1:0] grant_q;

  logic [1:0] req_v, rdy;
  logic       win, accept, sel_dcx, sel_last;
  logic [7:0] sel_data;
  logic       tmr_load, tmr_done;
  logic [CW-1:0] tmr_val;

  // Ready is combinational so a byte is accepted in the cycle it is offered.
  // In WAIT_NEXT only the burst owner may be accepted.
  always_comb begin
    req_v = {bus.req1_valid, bus.req0_valid};
    win   = REQ_CMD;
    rdy   = 2'b00;
    case (state)
      IDLE: begin
        win = (&req_v) ? ~last_served : req_v[REQ_PIX];
        if (|req_v) rdy = 2'b01 << win;
      end
      WAIT_NEXT: begin
        win = owner;
        if (req_v[owner]) rdy = 2'b01 << win;
      end
      default: ;
    endcase
  end

  assign accept   = |rdy;
  assign sel_dcx  = win ? bus.req1_dcx  : bus.req0_dcx;
  assign sel_data = win ? bus.req1_data : bus.req0_data;
  assign sel_last = win ? bus.req1_last : bus.req0_last;

  // One timer serves both phases: loaded with WR_LOW on accept, reloaded
  // with WR_HIGH as the low phase ends.
  assign tmr_load = accept | ((state == STROBE_LO) & tmr_done);
  assign tmr_val  = accept ? CW'(WR_LOW) : CW'(WR_HIGH);

  lcd_wr_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= REQ_CMD;
      last_served <= REQ_PIX;
      last_q      <= 1'b0;
      wr_q        <= 1'b1;
      dcx_q       <= DCX_DATA;
      d_q         <= 8'h00;
      grant_q     <= 2'b00;
    end else if (accept) begin
      owner       <= win;
      last_served <= win;
      last_q      <= sel_last;
      dcx_q       <= sel_dcx;
      d_q         <= sel_data;
      grant_q     <= 2'b01 << win;
      wr_q        <= 1'b0;
      state       <= STROBE_LO;
    end else begin
      case (state)
        STROBE_LO: if (tmr_done) begin
          wr_q  <= 1'b1;
          state <= STROBE_HI;
        end
        STROBE_HI: if (tmr_done) begin
          if (last_q) begin
            state   <= IDLE;
            grant_q <= 2'b00;
          end else begin
            state   <= WAIT_NEXT;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req0_ready = rdy[0];
  assign bus.req1_ready = rdy[1];
  assign bus.wr         = wr_q;
  assign bus.dcx        = dcx_q;
  assign bus.D          = d_q;
  assign bus.grant      = grant_q;
  assign bus.busy       = (state != IDLE);
endmodule
